// File: rtl/ollar_pkg.sv
// Shared widths, port count and controller state encoding for the ollar memory responder.
package ollar_pkg;

  localparam int WORD_W = 32;
  localparam int NPORTS = 4;
  localparam int PORT_W = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  function automatic logic [NPORTS-1:0] port_onehot(input logic [PORT_W-1:0] idx);
    return {{(NPORTS-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/ollar_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above ptr, wrapping.
module ollar_rr_arbiter
  import ollar_pkg::*;
(
  input  logic [NPORTS-1:0] req,
  input  logic [PORT_W-1:0] ptr,
  output logic [PORT_W-1:0] grant,
  output logic              any_req
);

  logic [PORT_W-1:0] idx;

  // Scan from the farthest offset down so the nearest request to ptr wins.
  always_comb begin
    grant   = ptr;
    any_req = 1'b0;
    idx     = ptr;
    for (int i = NPORTS - 1; i >= 0; i--) begin
      idx = ptr + PORT_W'(i);
      if (req[idx]) begin
        grant   = idx;
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ollar_mem_responder.sv
// Four-port shared memory responder: round-robin grant, one access in flight, fixed latency.
//   state  | meaning
//   IDLE   | arbitrate; latch granted port's request on any Req
//   ACCESS | perform the single RAM write or read for the latched request
//   RESP   | pulse Ack for the grant, present read data, advance the pointer
module ollar_mem_responder
  import ollar_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic                           CLOCK_PIN,
  input  logic                           RESET_PIN,
  input  logic [NPORTS-1:0]              Req,
  input  logic [NPORTS-1:0]              Write,
  input  logic [NPORTS-1:0][WORD_W-1:0]  Address,
  input  logic [NPORTS-1:0][WORD_W-1:0]  Output,
  output logic [NPORTS-1:0][WORD_W-1:0]  Input,
  output logic [NPORTS-1:0]              Ack
);

  state_t                          state_q, state_d;
  logic [PORT_W-1:0]               ptr_q;
  logic [PORT_W-1:0]               grant_q;
  logic                            wr_q;
  logic [AW-1:0]                   addr_q;
  logic [WORD_W-1:0]               wdata_q;
  logic [NPORTS-1:0][WORD_W-1:0]   hold_q;

  logic [PORT_W-1:0]               grant_sel;
  logic                            any_req;
  logic                            latch_req;
  logic                            mem_en;
  logic                            mem_we;
  logic                            rd_done;
  logic                            resp_done;
  logic [NPORTS-1:0]               ack_vec;

  logic [WORD_W-1:0]               mem [DEPTH];
  logic [WORD_W-1:0]               rdata_q;
  logic                            unused_addr_hi;

  ollar_rr_arbiter u_arb (
    .req     (Req),
    .ptr     (ptr_q),
    .grant   (grant_sel),
    .any_req (any_req)
  );

  always_ff @(posedge CLOCK_PIN or negedge RESET_PIN) begin
    if (!RESET_PIN) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    latch_req = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    rd_done   = 1'b0;
    resp_done = 1'b0;
    ack_vec   = '0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d   = ACCESS;
          latch_req = 1'b1;
        end
      end
      ACCESS: begin
        state_d = RESP;
        mem_en  = 1'b1;
        mem_we  = wr_q;
      end
      RESP: begin
        state_d   = IDLE;
        resp_done = 1'b1;
        rd_done   = !wr_q;
        ack_vec   = port_onehot(grant_q);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_PIN or negedge RESET_PIN) begin
    if (!RESET_PIN) begin
      ptr_q   <= '0;
      grant_q <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      hold_q  <= '0;
    end else begin
      if (latch_req) begin
        grant_q <= grant_sel;
        wr_q    <= Write[grant_sel];
        addr_q  <= Address[grant_sel][AW-1:0];
        wdata_q <= Output[grant_sel];
      end
      if (resp_done) ptr_q <= grant_q + PORT_W'(1);
      if (rd_done)   hold_q[grant_q] <= rdata_q;
    end
  end

  // Memory contents survive reset; an aborted write never sees mem_en because state resets first.
  always_ff @(posedge CLOCK_PIN) begin
    if (mem_en) begin
      if (mem_we) mem[addr_q] <= wdata_q;
      else        rdata_q     <= mem[addr_q];
    end
  end

  // The RAM output register feeds the granted port during RESP; hold_q keeps it afterwards.
  always_comb begin
    Input = hold_q;
    if (state_q == RESP && !wr_q) Input[grant_q] = rdata_q;
  end

  assign Ack = ack_vec;

  always_comb begin
    unused_addr_hi = 1'b0;
    for (int p = 0; p < NPORTS; p++) unused_addr_hi = unused_addr_hi ^ (^Address[p][WORD_W-1:AW]);
  end

endmodule

// File: tb/tb_ollar_mem_responder.sv
// Directed scoreboard bench for ollar_mem_responder: expected Acks are queued at issue time.
module tb_ollar_mem_responder;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [3:0]        req, wr, ack;
  logic [3:0][31:0]  addr, wdata, rdata;
  logic [3:0][31:0]  model;
  int                rem [4];
  int                cyc = 0;
  int                n_checks = 0;
  int                n_pass = 0;
  int                c;

  typedef struct {
    int          port;
    bit          is_wr;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t sb [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ollar_mem_responder #(.DEPTH(256), .AW(8)) dut (
    .CLOCK_PIN (clk),
    .RESET_PIN (rst_n),
    .Req       (req),
    .Write     (wr),
    .Address   (addr),
    .Output    (wdata),
    .Input     (rdata),
    .Ack       (ack)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  task automatic set_port(input int p, input bit w, input logic [31:0] a, input logic [31:0] d,
                          input int n);
    req[p]   = 1'b1;
    wr[p]    = w;
    addr[p]  = a;
    wdata[p] = d;
    rem[p]   = n;
  endtask

  task automatic expect_ack(input int p, input bit w, input logic [31:0] d, input int at);
    exp_t e;
    e.port  = p;
    e.is_wr = w;
    e.data  = d;
    e.cyc   = at;
    sb.push_back(e);
  endtask

  task automatic sample();
    exp_t e;
    if (ack != 4'b0) begin
      if (sb.size() == 0) begin
        chk("spurious_ack", {124'b0, ack}, 128'b0);
      end else begin
        e = sb.pop_front();
        chk("ack_port", {124'b0, ack}, {124'b0, 4'b1 << e.port});
        chk("ack_cycle", cyc, e.cyc);
        if (!e.is_wr) model[e.port] = e.data;
        rem[e.port]--;
        if (rem[e.port] == 0) req[e.port] = 1'b0;
      end
    end
    chk("input_words", rdata, model);
  endtask

  task automatic run(input int budget);
    int n;
    n = 0;
    while ((sb.size() != 0 || req != 4'b0) && n < budget) begin
      @(negedge clk);
      n++;
      sample();
    end
    chk("drain_pending", sb.size(), 0);
    sb.delete();
    req = 4'b0;
    @(negedge clk);
    sample();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model = '0;
    req   = 4'b0;
    chk("reset_ack", {124'b0, ack}, 128'b0);
    chk("reset_input", rdata, 128'b0);
    @(negedge clk);
    chk("reset_hold_ack", {124'b0, ack}, 128'b0);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b0;
    wr    = 4'b0;
    addr  = '0;
    wdata = '0;
    model = '0;
    for (int p = 0; p < 4; p++) rem[p] = 0;
    repeat (2) @(negedge clk);
    chk("por_ack", {124'b0, ack}, 128'b0);
    chk("por_input", rdata, 128'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Port 0 write then read-back, each acked two edges after issue.
    c = cyc;
    set_port(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1);
    expect_ack(0, 1'b1, 32'h0, c + 2);
    run(20);
    c = cyc;
    set_port(0, 1'b0, 32'h10, $urandom, 1);
    expect_ack(0, 1'b0, 32'hDEAD_BEEF, c + 2);
    run(20);
    chk("p0_readback", rdata[0], 32'hDEAD_BEEF);

    for (int i = 0; i < 4; i++) begin
      c = cyc;
      set_port(0, 1'b1, 32'h40 + i, 32'h1111_0000 + i, 1);
      expect_ack(0, 1'b1, 32'h0, c + 2);
      run(20);
    end

    // All four ports after reset: order 0..3, one Ack every 3 cycles.
    do_reset();
    c = cyc;
    for (int p = 0; p < 4; p++) begin
      set_port(p, 1'b0, 32'h40 + p, $urandom, 1);
      expect_ack(p, 1'b0, 32'h1111_0000 + p, c + 2 + 3 * p);
    end
    run(40);

    // Address 0x100 aliases to 0x000.
    c = cyc;
    set_port(2, 1'b1, 32'h100, 32'h1234_5678, 1);
    expect_ack(2, 1'b1, 32'h0, c + 2);
    run(20);
    c = cyc;
    set_port(3, 1'b0, 32'h000, $urandom, 1);
    expect_ack(3, 1'b0, 32'h1234_5678, c + 2);
    run(20);
    chk("alias_read", rdata[3], 32'h1234_5678);

    // Port 0 read completes while port 2 waits; Input[2] must hold its old word.
    c = cyc;
    set_port(0, 1'b0, 32'h10, $urandom, 1);
    set_port(2, 1'b0, 32'h41, $urandom, 1);
    expect_ack(0, 1'b0, 32'hDEAD_BEEF, c + 2);
    expect_ack(2, 1'b0, 32'h1111_0001, c + 5);
    run(30);

    // Reset during ACCESS drops the write and restarts the pointer at 0.
    c = cyc;
    set_port(1, 1'b1, 32'h20, 32'hAAAA_0001, 1);
    expect_ack(1, 1'b1, 32'h0, c + 2);
    run(20);
    set_port(1, 1'b1, 32'h20, 32'hBBBB_0002, 1);
    @(negedge clk);
    chk("abort_no_ack", {124'b0, ack}, 128'b0);
    do_reset();
    c = cyc;
    set_port(1, 1'b0, 32'h20, $urandom, 1);
    set_port(3, 1'b0, 32'h10, $urandom, 1);
    expect_ack(1, 1'b0, 32'hAAAA_0001, c + 2);
    expect_ack(3, 1'b0, 32'hDEAD_BEEF, c + 5);
    run(30);

    // Ports 1 and 3 held continuously alternate 1,3,1,3.
    c = cyc;
    set_port(1, 1'b0, 32'h20, $urandom, 2);
    set_port(3, 1'b0, 32'h43, $urandom, 2);
    expect_ack(1, 1'b0, 32'hAAAA_0001, c + 2);
    expect_ack(3, 1'b0, 32'h1111_0003, c + 5);
    expect_ack(1, 1'b0, 32'hAAAA_0001, c + 8);
    expect_ack(3, 1'b0, 32'h1111_0003, c + 11);
    run(40);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
